// File: rtl/pps_measure.sv
// pps_measure: measures period, low width and count of an async active-low pulse train; optional glitch filter via PPS_GLITCH_FILT_EN
module pps_measure #(
  parameter int CNT_W       = 32,
  parameter int NOM_CYC     = 14410,
  parameter int TOL_CYC     = 4,
  parameter int TIMEOUT_CYC = 28820,
  parameter int LOCK_N      = 3,
  parameter int FILT_LEN    = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en_i,
  input  logic             pps_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic             meas_valid_o,
  output logic             lost_o,
  output logic             locked_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_LOST} state_t;
  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(NOM_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(NOM_CYC + TOL_CYC);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

  if (FILT_LEN < 1) begin : g_bad_filt
    $error("FILT_LEN must be at least 1");
  end

  state_t           state;
  logic             s1, s2, pps_f, pps_d;
  logic [CNT_W-1:0] per_cnt, wid_cnt, wid_hold, per_meas;
  logic [LW-1:0]    lock_cnt, lock_nxt;
  logic             fall, rise, timeout, in_tol;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction

  // two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      pps_d <= 1'b1;
    end else begin
      s1    <= pps_in;
      s2    <= s1;
      pps_d <= pps_f;
    end
  end

`ifdef PPS_GLITCH_FILT_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] fcnt;
  // follow the synchronised level only once it has held for FILT_LEN cycles
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pps_f <= 1'b1;
      fcnt  <= '0;
    end else if (s2 == pps_f) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT_LEN - 1)) begin
      pps_f <= s2;
      fcnt  <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end
`else
  assign pps_f = s2;
`endif

  assign fall     = pps_d & ~pps_f;
  assign rise     = ~pps_d & pps_f;
  assign timeout  = (state != S_LOST) && (per_cnt >= TO_LAST);
  assign per_meas = sat_inc(per_cnt);
  assign in_tol   = (per_meas >= LO_LIM) && (per_meas <= HI_LIM);
  assign lock_nxt = !in_tol ? '0 : (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;

  // measurement state machine; a fall outranks a timeout, disable outranks everything
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      per_cnt      <= '0;
      wid_cnt      <= '0;
      wid_hold     <= '0;
      lock_cnt     <= '0;
      period_o     <= '0;
      width_o      <= '0;
      pulse_cnt_o  <= '0;
      meas_valid_o <= 1'b0;
      lost_o       <= 1'b0;
      locked_o     <= 1'b0;
    end else if (!en_i) begin
      state        <= S_IDLE;
      per_cnt      <= '0;
      wid_cnt      <= '0;
      lock_cnt     <= '0;
      meas_valid_o <= 1'b0;
      lost_o       <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      per_cnt      <= sat_inc(per_cnt);
      if (state == S_LOW) wid_cnt <= sat_inc(wid_cnt);
      if (fall && state != S_LOW) begin
        state   <= S_LOW;
        per_cnt <= '0;
        wid_cnt <= '0;
        lost_o  <= 1'b0;
        if (state == S_HIGH) begin
          period_o     <= per_meas;
          width_o      <= wid_hold;
          meas_valid_o <= 1'b1;
          pulse_cnt_o  <= pulse_cnt_o + 1'b1;
          lock_cnt     <= lock_nxt;
          locked_o     <= lock_nxt == LOCK_MAX;
        end
      end else if (timeout) begin
        state    <= S_LOST;
        lost_o   <= 1'b1;
        locked_o <= 1'b0;
        lock_cnt <= '0;
      end else if (state == S_LOW && rise) begin
        wid_hold <= sat_inc(wid_cnt);
        state    <= S_HIGH;
      end
    end
  end
endmodule

// File: tb/tb_pps_measure.sv
// tb_pps_measure: randomized pulse trains checked against an edge-spacing model of pps_measure
module tb_pps_measure;
  localparam int CW = 32, NOM = 100, TOL = 4, TO = 200, LN = 3, FILT = 4;
`ifdef PPS_GLITCH_FILT_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic aclk = 1'b0, aresetn = 1'b0, en_i = 1'b0, pps_in = 1'b1;
  logic [CW-1:0] period_o, width_o, pulse_cnt_o;
  logic meas_valid_o, lost_o, locked_o;

  int passed = 0, total = 0, strobes = 0;
  logic [CW-1:0] last_per = '0, last_wid = '0;
  int armed = 0, prev_gap = 0, prev_low = 0, lockrun = 0, pubs = 0, pub_per = 0, pub_wid = 0;

  pps_measure #(.CNT_W(CW), .NOM_CYC(NOM), .TOL_CYC(TOL), .TIMEOUT_CYC(TO), .LOCK_N(LN), .FILT_LEN(FILT)) dut (
    .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .pps_in(pps_in),
    .period_o(period_o), .width_o(width_o), .pulse_cnt_o(pulse_cnt_o),
    .meas_valid_o(meas_valid_o), .lost_o(lost_o), .locked_o(locked_o)
  );

  always #5 aclk = ~aclk;

  // record every strobe and the values it published
  always @(negedge aclk) begin
    if (meas_valid_o) begin
      strobes = strobes + 1;
      last_per = period_o;
      last_wid = width_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // one pulse: fall, low for 'low' cycles, high for 'high' cycles (optional 2-cycle glitch in the high phase)
  task automatic pulse(input int low, input int high, input int glitch_at = 0);
    int s0;
    logic exp_pub;
    s0 = strobes;
    exp_pub = (armed != 0) && (prev_gap <= TO);
    pps_in = 1'b0;
    repeat (low) @(negedge aclk);
    pps_in = 1'b1;
    if (glitch_at > 0 && glitch_at + 2 < high) begin
      repeat (glitch_at) @(negedge aclk);
      pps_in = 1'b0;
      repeat (2) @(negedge aclk);
      pps_in = 1'b1;
      repeat (high - glitch_at - 2) @(negedge aclk);
    end else begin
      repeat (high) @(negedge aclk);
    end
    if (exp_pub) begin
      pubs++;
      pub_per = prev_gap;
      pub_wid = prev_low;
      lockrun = (prev_gap >= NOM - TOL && prev_gap <= NOM + TOL) ? ((lockrun < LN) ? lockrun + 1 : LN) : 0;
    end
    chk("strobe_count", strobes - s0, {63'd0, exp_pub});
    if (exp_pub) begin
      chk("period", last_per, pub_per);
      chk("width", last_wid, pub_wid);
    end
    armed = 1;
    prev_gap = low + high;
    prev_low = low;
    if (low + high >= TO + LAT) lockrun = 0;
    chk("lost", lost_o, low + high >= TO + LAT);
    chk("locked", locked_o, lockrun == LN);
    chk("pulse_cnt", pulse_cnt_o, pubs);
  endtask

  initial begin
    int since, s0;
    repeat (4) @(negedge aclk);
    chk("rst_period", period_o, 0);
    chk("rst_width", width_o, 0);
    chk("rst_cnt", pulse_cnt_o, 0);
    chk("rst_valid", meas_valid_o, 0);
    chk("rst_lost", lost_o, 0);
    chk("rst_locked", locked_o, 0);
    aresetn = 1'b1;
    en_i = 1'b1;
    repeat (3) @(negedge aclk);

    repeat (5) pulse(20, NOM - 20);
    pulse(20, NOM + 10 - 20);
    repeat (4) pulse(20, NOM - 20);

    for (int i = 0; i < 16; i++) begin
      int p, l;
      p = int'($urandom_range(NOM + 8, NOM - 8));
      l = int'($urandom_range(30, 5));
      pulse(l, p - l);
    end

    repeat (4) pulse(20, NOM - 20);
    pulse(20, 0);
    since = 20;
    while (!lost_o && since < TO + LAT + 50) begin
      @(negedge aclk);
      since++;
    end
    chk("loss_latency", since, TO + LAT);
    chk("loss_lost", lost_o, 1);
    chk("loss_locked", locked_o, 0);
    prev_gap = since;
    lockrun = 0;
    pulse(20, NOM - 20);
    pulse(20, NOM - 20);

    pulse(TO + 50, 30);
    pulse(20, NOM - 20);
    pulse(20, NOM - 20);

    repeat (4) pulse(20, NOM - 20);
    pulse(10, 0);
    s0 = strobes;
    en_i = 1'b0;
    repeat (20) @(negedge aclk);
    chk("dis_strobes", strobes - s0, 0);
    chk("dis_lost", lost_o, 0);
    chk("dis_locked", locked_o, 0);
    chk("dis_period", period_o, pub_per);
    chk("dis_width", width_o, pub_wid);
    chk("dis_cnt", pulse_cnt_o, pubs);
    en_i = 1'b1;
    armed = 0;
    lockrun = 0;
    pulse(20, NOM - 20);
    pulse(20, NOM - 20);

`ifdef PPS_GLITCH_FILT_EN
    pulse(20, NOM - 20, 30);
    pulse(20, NOM - 20);
    pulse(20, NOM - 20);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
